// File: rtl/rx_serial_7o1.sv
// rx_serial_7o1 -- receiver for the 7O1 asynchronous serial format.
//
// Frame: start (0), 7 data bits LSB first, odd parity bit, stop (1); line idles high.
// The line is synchronised, each bit is sampled at its centre, and the received
// character is held until the consumer acknowledges it.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   entrada_serial asynchronous serial line (idle 1)
//   recebe_dado    consumer acknowledge, clears tem_dado
//   dados_ascii    last received character
//   paridade_ok    last frame had odd parity over data+parity
//   erro_stop      last frame's stop bit was sampled 0
//   pronto         one-cycle pulse when a frame has been stored
//   tem_dado       character held and not yet acknowledged
//   erro_overrun   sticky: a frame was stored while tem_dado was 1
//   db_tick        one-cycle pulse at every sample instant
//   db_estado      current FSM state code
module rx_serial_7o1 #(
  parameter int CICLOS_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebe_dado,
  output logic [6:0] dados_ascii,
  output logic       paridade_ok,
  output logic       erro_stop,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_overrun,
  output logic       db_tick,
  output logic [3:0] db_estado
);

  localparam int CW = $clog2(CICLOS_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CICLOS_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CICLOS_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    START    = 4'd2,
    DADOS    = 4'd3,
    STOP     = 4'd4,
    ARMAZENA = 4'd5
  } state_t;

  state_t        state_reg;
  logic          sync_meta_reg;
  logic          s_reg;
  logic          armed_reg;
  logic [CW-1:0] tick_cnt_reg;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          tick;

  // Two-flop synchroniser. Resetting to 1 (idle) keeps a reset release
  // from looking like a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta_reg <= 1'b1;
      s_reg         <= 1'b1;
    end else begin
      sync_meta_reg <= entrada_serial;
      s_reg         <= sync_meta_reg;
    end
  end

  // Sample instant: half a bit into START (centre of the start bit), then one
  // full bit period per sample in DADOS and STOP.
  always_comb begin
    tick = 1'b0;
    case (state_reg)
      START:       tick = (tick_cnt_reg == HALF_M1);
      DADOS, STOP: tick = (tick_cnt_reg == FULL_M1);
      default:     tick = 1'b0;
    endcase
  end

  assign db_tick   = tick;
  assign db_estado = 4'(state_reg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= INICIAL;
      armed_reg    <= 1'b0;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'd0;
      dados_ascii  <= 7'd0;
      paridade_ok  <= 1'b0;
      erro_stop    <= 1'b0;
      pronto       <= 1'b0;
      tem_dado     <= 1'b0;
      erro_overrun <= 1'b0;
    end else begin
      pronto <= 1'b0;
      // The store below is written later in this block, so a simultaneous
      // store overrides the acknowledge.
      if (recebe_dado) tem_dado <= 1'b0;

      case (state_reg)
        INICIAL: begin
          armed_reg    <= 1'b0;
          tick_cnt_reg <= '0;
          state_reg    <= ESPERA;
        end

        ESPERA: begin
          tick_cnt_reg <= '0;
          bit_cnt_reg  <= 4'd0;
          // Only a 1->0 transition starts a frame, so a line stuck low
          // (break) cannot retrigger until it has gone back high.
          if (armed_reg && !s_reg) begin
            state_reg <= START;
          end else if (s_reg) begin
            armed_reg <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            tick_cnt_reg <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state_reg    <= s_reg ? ESPERA : DADOS;
          end else begin
            tick_cnt_reg <= tick_cnt_reg + CNT_ONE;
          end
        end

        DADOS: begin
          if (tick) begin
            tick_cnt_reg <= '0;
            // Shift in from the top: after 8 samples bit0 sits in [0]
            // and the parity bit in [7].
            shift_reg    <= {s_reg, shift_reg[7:1]};
            if (bit_cnt_reg == 4'd7) begin
              bit_cnt_reg <= 4'd0;
              state_reg   <= STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end else begin
            tick_cnt_reg <= tick_cnt_reg + CNT_ONE;
          end
        end

        STOP: begin
          if (tick) begin
            tick_cnt_reg <= '0;
            // Output registers are written on the edge into ARMAZENA so
            // that they, tem_dado and pronto all appear in the ARMAZENA cycle.
            dados_ascii  <= shift_reg[6:0];
            paridade_ok  <= ^shift_reg;
            erro_stop    <= ~s_reg;
            erro_overrun <= erro_overrun | tem_dado;
            tem_dado     <= 1'b1;
            pronto       <= 1'b1;
            state_reg    <= ARMAZENA;
          end else begin
            tick_cnt_reg <= tick_cnt_reg + CNT_ONE;
          end
        end

        ARMAZENA: begin
          armed_reg <= 1'b0;
          state_reg <= ESPERA;
        end

        default: state_reg <= INICIAL;
      endcase
    end
  end

endmodule
